// File: rtl/key_event_scheduler_pkg.sv
// Shared types and constants for the key event scheduler: FSM states,
// request slot indices, value-register limits and the round-robin step.
package key_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    SOUND = 2'd2,
    GAP   = 2'd3
  } state_e;

  localparam int NUM_REQ  = 3;
  localparam int REQ_INC  = 0;
  localparam int REQ_DEC  = 1;
  localparam int REQ_BEEP = 2;

  localparam logic [3:0] CNT_MAX = 4'd15;
  localparam logic [3:0] CNT_MIN = 4'd0;

  // (idx + k) modulo the three request slots
  function automatic logic [1:0] rr_add(input logic [1:0] idx, input logic [1:0] k);
    logic [2:0] s;
    s = {1'b0, idx} + {1'b0, k};
    if (s >= 3'd3) s = s - 3'd3;
    return s[1:0];
  endfunction

endpackage

// File: rtl/key_event_scheduler_tone_gen.sv
// Square-wave buzzer tone: toggles every TONE_HALF enabled cycles,
// restarts low on clear and is forced low while disabled.
module tone_gen #(
  parameter int TONE_HALF = 113636
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic clr_i,
  output logic wave_o
);

  localparam int CW = (TONE_HALF > 1) ? $clog2(TONE_HALF) : 1;

  logic [CW-1:0] cnt_q;
  logic          wave_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      wave_q <= 1'b0;
    end else if (clr_i) begin
      cnt_q  <= '0;
      wave_q <= 1'b0;
    end else if (en_i) begin
      if (cnt_q == CW'(TONE_HALF - 1)) begin
        cnt_q  <= '0;
        wave_q <= ~wave_q;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  // Gating keeps the pin low outside SOUND and drops it with an async reset.
  assign wave_o = wave_q & en_i;

endmodule

// File: rtl/key_event_scheduler.sv
// Round-robin scheduler of inc/dec/beep key requests onto the 4-bit value
// register and buzzer. Define KEY_SCHED_CLICK_EN to sound a click on accepted inc/dec.
module key_event_scheduler
  import key_sched_pkg::*;
#(
  parameter int TONE_HALF = 113636,
  parameter int BEEP_CYC  = 5000000,
  parameter int CLICK_CYC = 1000000,
  parameter int GAP_CYC   = 2500000
) (
  input  logic       FPGA_CLK,
  input  logic       RESET_BUT,
  input  logic       req_inc,
  input  logic       req_dec,
  input  logic       req_beep,
  input  logic [3:0] cnt_val,
  output logic       cnt_inc,
  output logic       cnt_dec,
  output logic       beep,
  output logic       busy,
  output logic       drop
);

  state_e      state_q, state_d;
  logic [2:0]  pend_q, pend_d;
  logic [2:0]  req_v, gnt_mask;
  logic [1:0]  ptr_q, ptr_d;
  logic [1:0]  gnt_q, gnt_d;
  logic [1:0]  pick, cand;
  logic        pick_vld;
  logic [31:0] dur_q, dur_d;
  logic [31:0] snd_last_q, snd_last_d;
  logic        drop_q, drop_d;
  logic        acc_inc, acc_dec, accept;

  assign req_v = {req_beep, req_dec, req_inc};

  // First pending slot at or after the pointer wins.
  always_comb begin
    pick     = ptr_q;
    pick_vld = 1'b0;
    cand     = ptr_q;
    for (int k = 2; k >= 0; k--) begin
      cand = rr_add(ptr_q, 2'(k));
      if (pend_q[cand]) begin
        pick     = cand;
        pick_vld = 1'b1;
      end
    end
  end

  assign gnt_mask = (state_q == IDLE && pick_vld) ? (3'b001 << pick) : 3'b000;
  // A request landing on its own grant cycle survives as a fresh pending bit.
  assign pend_d   = (pend_q & ~gnt_mask) | req_v;
  assign drop_d   = |(req_v & pend_q & ~gnt_mask);

  assign acc_inc = (state_q == ISSUE) && (gnt_q == 2'(REQ_INC)) && (cnt_val != CNT_MAX);
  assign acc_dec = (state_q == ISSUE) && (gnt_q == 2'(REQ_DEC)) && (cnt_val != CNT_MIN);
  assign accept  = acc_inc | acc_dec;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    gnt_d      = gnt_q;
    dur_d      = dur_q;
    snd_last_d = snd_last_q;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d = ISSUE;
          gnt_d   = pick;
          ptr_d   = rr_add(pick, 2'd1);
        end
      end
      ISSUE: begin
        dur_d = '0;
`ifdef KEY_SCHED_CLICK_EN
        state_d    = SOUND;
        snd_last_d = accept ? 32'(CLICK_CYC - 1) : 32'(BEEP_CYC - 1);
`else
        state_d    = accept ? GAP : SOUND;
        snd_last_d = 32'(BEEP_CYC - 1);
`endif
      end
      SOUND: begin
        if (dur_q == snd_last_q) begin
          state_d = GAP;
          dur_d   = '0;
        end else begin
          dur_d = dur_q + 32'd1;
        end
      end
      GAP: begin
        if (dur_q == 32'(GAP_CYC - 1)) begin
          state_d = IDLE;
          dur_d   = '0;
        end else begin
          dur_d = dur_q + 32'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge FPGA_CLK or posedge RESET_BUT) begin
    if (RESET_BUT) begin
      state_q    <= IDLE;
      pend_q     <= '0;
      ptr_q      <= 2'(REQ_INC);
      gnt_q      <= 2'(REQ_INC);
      dur_q      <= '0;
      snd_last_q <= '0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      ptr_q      <= ptr_d;
      gnt_q      <= gnt_d;
      dur_q      <= dur_d;
      snd_last_q <= snd_last_d;
      drop_q     <= drop_d;
    end
  end

  tone_gen #(
    .TONE_HALF(TONE_HALF)
  ) u_tone (
    .clk_i (FPGA_CLK),
    .rst_i (RESET_BUT),
    .en_i  (state_q == SOUND),
    .clr_i (state_q == ISSUE),
    .wave_o(beep)
  );

  assign cnt_inc = acc_inc;
  assign cnt_dec = acc_dec;
  assign busy    = (state_q != IDLE);
  assign drop    = drop_q;

endmodule

// File: tb/tb_key_event_scheduler.sv
// Self-checking bench for key_event_scheduler: table-driven single commands,
// then arbitration order, drop, and mid-sound reset sequences.
module tb_key_event_scheduler;

  localparam int TH  = 4;
  localparam int CLK = 8;
  localparam int BP  = 20;
  localparam int GP  = 5;
`ifdef KEY_SCHED_CLICK_EN
  localparam int CL = CLK;
`else
  localparam int CL = 0;
`endif

  logic       FPGA_CLK, RESET_BUT, req_inc, req_dec, req_beep;
  logic [3:0] cnt_val;
  logic       cnt_inc, cnt_dec, beep, busy, drop;

  key_event_scheduler #(
    .TONE_HALF(TH), .BEEP_CYC(BP), .CLICK_CYC(CLK), .GAP_CYC(GP)
  ) dut (
    .FPGA_CLK(FPGA_CLK), .RESET_BUT(RESET_BUT),
    .req_inc(req_inc), .req_dec(req_dec), .req_beep(req_beep),
    .cnt_val(cnt_val), .cnt_inc(cnt_inc), .cnt_dec(cnt_dec),
    .beep(beep), .busy(busy), .drop(drop)
  );

  initial FPGA_CLK = 1'b0;
  always #5 FPGA_CLK = ~FPGA_CLK;

  int cyc = 0;
  always @(posedge FPGA_CLK) cyc <= cyc + 1;

  typedef struct {
    logic       ri, rd, rb;
    logic [3:0] val;
    logic       e_inc, e_dec;
    int         snd;
  } vec_t;

  typedef struct {
    logic s_inc, s_dec;
    int   busy_len, high, frise;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   drop_cnt = 0;
  int   both_cnt = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge FPGA_CLK);
    if (drop) drop_cnt++;
    if (cnt_inc && cnt_dec) both_cnt++;
  endtask

  function automatic exp_t mk_exp(input logic i, input logic d, input int snd);
    exp_t e;
    e.s_inc    = i;
    e.s_dec    = d;
    e.busy_len = 1 + snd + GP;
    e.high     = 0;
    for (int c = 0; c < snd; c++) if (((c / TH) % 2) == 1) e.high++;
    e.frise    = (snd > TH) ? 1 + TH : -1;
    return e;
  endfunction

  task automatic pulse(input logic [2:0] m);
    {req_beep, req_dec, req_inc} = m;
    tick();
    {req_beep, req_dec, req_inc} = 3'b000;
  endtask

  // Waits for one command, measures it while optionally injecting requests, checks it against the scoreboard.
  task automatic observe(input logic [2:0] inj_mask, input logic [31:0] inj_sched, output int start_cyc);
    int   t, n, incs, decs, high, frise, stb;
    exp_t e;
    t = 0; n = 0; incs = 0; decs = 0; high = 0; frise = -1; stb = -1;
    while (!busy && t < 300) begin tick(); t++; end
    start_cyc = busy ? cyc : -1;
    chk("cmd_start", int'(busy), 1);
    while (busy && n < 200) begin
      if (cnt_inc) incs++;
      if (cnt_dec) decs++;
      if ((cnt_inc || cnt_dec) && stb < 0) stb = n;
      if (beep) begin high++; if (frise < 0) frise = n; end
      {req_beep, req_dec, req_inc} = (n < 32 && inj_sched[n]) ? inj_mask : 3'b000;
      tick();
      n++;
    end
    {req_beep, req_dec, req_inc} = 3'b000;
    if (exp_q.size() == 0) begin
      chk("sb_empty", 1, 0);
    end else begin
      e = exp_q.pop_front();
      chk("busy_len", n, e.busy_len);
      chk("inc_strobes", incs, int'(e.s_inc));
      chk("dec_strobes", decs, int'(e.s_dec));
      chk("strobe_pos", stb, (e.s_inc || e.s_dec) ? 0 : -1);
      chk("beep_high", high, e.high);
      chk("beep_first", frise, e.frise);
    end
    $display("cmd @%0d: len=%0d inc=%0d dec=%0d beep_high=%0d", start_cyc, n, incs, decs, high);
  endtask

  vec_t tbl[8];
  int   c0, s1, s2, s3, s4, busy_seen, t;

  initial begin
    tbl[0] = '{1'b1, 1'b0, 1'b0, 4'd3,  1'b1, 1'b0, CL};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 4'd0,  1'b0, 1'b0, BP};
    tbl[2] = '{1'b1, 1'b0, 1'b0, 4'd15, 1'b0, 1'b0, BP};
    tbl[3] = '{1'b0, 1'b1, 1'b0, 4'd9,  1'b0, 1'b1, CL};
    tbl[4] = '{1'b0, 1'b0, 1'b1, 4'd15, 1'b0, 1'b0, BP};
    tbl[5] = '{1'b1, 1'b0, 1'b0, 4'd14, 1'b1, 1'b0, CL};
    tbl[6] = '{1'b0, 1'b1, 1'b0, 4'd1,  1'b0, 1'b1, CL};
    tbl[7] = '{1'b0, 1'b0, 1'b1, 4'd0,  1'b0, 1'b0, BP};

    RESET_BUT = 1'b1; req_inc = 0; req_dec = 0; req_beep = 0; cnt_val = 4'd0;
    repeat (3) tick();
    chk("rst_busy", int'(busy), 0);
    chk("rst_beep", int'(beep), 0);
    chk("rst_inc", int'(cnt_inc), 0);
    chk("rst_dec", int'(cnt_dec), 0);
    chk("rst_drop", int'(drop), 0);
    RESET_BUT = 1'b0;
    tick();

    for (int i = 0; i < 8; i++) begin
      cnt_val = tbl[i].val;
      exp_q.push_back(mk_exp(tbl[i].e_inc, tbl[i].e_dec, tbl[i].snd));
      c0 = cyc;
      pulse({tbl[i].rb, tbl[i].rd, tbl[i].ri});
      observe(3'b000, 32'h0, s1);
      chk("latency", s1 - c0, 2);
    end

    // All three at once, plus a fresh inc just after the inc grant.
    cnt_val = 4'd7;
    exp_q.push_back(mk_exp(1'b1, 1'b0, CL));
    exp_q.push_back(mk_exp(1'b0, 1'b1, CL));
    exp_q.push_back(mk_exp(1'b0, 1'b0, BP));
    exp_q.push_back(mk_exp(1'b1, 1'b0, CL));
    c0 = cyc;
    pulse(3'b111);
    observe(3'b001, 32'h4, s1);
    chk("rr_latency", s1 - c0, 2);
    observe(3'b000, 32'h0, s2);
    observe(3'b000, 32'h0, s3);
    observe(3'b000, 32'h0, s4);
    chk("spacing_1", int'(s2 - s1 >= 1 + CL + GP), 1);
    chk("spacing_2", int'(s3 - s2 >= 1 + CL + GP), 1);
    chk("spacing_3", int'(s4 - s3 >= 1 + BP + GP), 1);

    // Two beep requests while busy: one drop, one tone.
    drop_cnt = 0;
    exp_q.push_back(mk_exp(1'b1, 1'b0, CL));
    exp_q.push_back(mk_exp(1'b0, 1'b0, BP));
    pulse(3'b001);
    observe(3'b100, 32'h14, s1);
    observe(3'b000, 32'h0, s2);
    chk("drop_pulses", drop_cnt, 1);
    busy_seen = 0;
    repeat (40) begin tick(); if (busy) busy_seen++; end
    chk("no_extra_cmd", busy_seen, 0);

    // Reset in the middle of a rejected-dec tone.
    cnt_val = 4'd0;
    pulse(3'b010);
    t = 0;
    while (!busy && t < 50) begin tick(); t++; end
    chk("pre_rst_busy", int'(busy), 1);
    repeat (6) tick();
    chk("pre_rst_beep", int'(beep), 1);
    #2 RESET_BUT = 1'b1;
    #1;
    chk("mid_rst_beep", int'(beep), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_inc", int'(cnt_inc), 0);
    chk("mid_rst_dec", int'(cnt_dec), 0);
    tick();
    tick();
    RESET_BUT = 1'b0;
    tick();
    cnt_val = 4'd7;
    exp_q.push_back(mk_exp(1'b1, 1'b0, CL));
    exp_q.push_back(mk_exp(1'b0, 1'b0, BP));
    c0 = cyc;
    pulse(3'b101);
    observe(3'b000, 32'h0, s1);
    chk("post_rst_latency", s1 - c0, 2);
    observe(3'b000, 32'h0, s2);

    chk("strobe_excl", both_cnt, 0);
    chk("sb_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
